// File: rtl/sram_arb_2p.sv
// Two-requester round-robin arbiter/controller for a 16x8 synchronous SRAM.
// Writes commit at the grant edge; reads return one cycle later with an rvalid pulse.
module sram_arb_2p #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  output logic              sram_we,
  input  logic [DATA_W-1:0] sram_dout
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } state_t;

  state_t r_state;
  logic   r_prio;
  logic   r_rd_port;
  logic   w_idle;
  logic   w_gnt0;
  logic   w_gnt1;
  logic   w_rd_grant;

  // Grants are combinational and suppressed while reset is asserted.
  always_comb begin
    w_idle     = (r_state == ST_IDLE) && !rst;
    w_gnt0     = w_idle && req0 && (!req1 || (r_prio == 1'b0));
    w_gnt1     = w_idle && req1 && (!req0 || (r_prio == 1'b1));
    w_rd_grant = (w_gnt0 && !wr0) || (w_gnt1 && !wr1);
    gnt0       = w_gnt0;
    gnt1       = w_gnt1;
  end

  // SRAM pins follow the granted port; idle value is a harmless read of address 0.
  always_comb begin
    sram_addr = {ADDR_W{1'b0}};
    sram_din  = {DATA_W{1'b0}};
    sram_we   = 1'b1;
    if (w_gnt0) begin
      sram_addr = addr0;
      sram_din  = wdata0;
      sram_we   = ~wr0;
    end else if (w_gnt1) begin
      sram_addr = addr1;
      sram_din  = wdata1;
      sram_we   = ~wr1;
    end else begin
      sram_addr = {ADDR_W{1'b0}};
      sram_din  = {DATA_W{1'b0}};
      sram_we   = 1'b1;
    end
  end

  // Control FSM, round-robin priority and registered read-return path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_prio    <= 1'b0;
      r_rd_port <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= {DATA_W{1'b0}};
      rdata1    <= {DATA_W{1'b0}};
    end else begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_prio <= w_gnt0 ? 1'b1 : 1'b0;
          end
          if (w_rd_grant) begin
            r_state   <= ST_RD_WAIT;
            r_rd_port <= w_gnt1;
          end
        end
        ST_RD_WAIT: begin
          r_state <= ST_IDLE;
          if (r_rd_port == 1'b0) begin
            rvalid0 <= 1'b1;
            rdata0  <= sram_dout;
          end else begin
            rvalid1 <= 1'b1;
            rdata1  <= sram_dout;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
